// File: rtl/acc_mux_datapath_if.sv
// Control/data bundle between the BIP control unit, data memory and the
// accumulator datapath slice.
interface acc_mux_datapath_if #(
    parameter int NBITS_D = 16
);
    logic [1:0]         i_SelA;
    logic               i_SelB;
    logic               i_WrAcc;
    logic               i_Op;
    logic [NBITS_D-1:0] i_OutData;
    logic [NBITS_D-1:0] i_ExtensionData;
    logic [NBITS_D-1:0] o_ACC;
    logic [NBITS_D-1:0] o_SelB;
    logic [NBITS_D-1:0] o_ALU;
    logic               o_Zero;
    logic               o_Carry;
    logic               o_Ovf;

    // Control unit / memory side: drives selects and operands, observes results.
    modport master (
        output i_SelA, i_SelB, i_WrAcc, i_Op, i_OutData, i_ExtensionData,
        input  o_ACC, o_SelB, o_ALU, o_Zero, o_Carry, o_Ovf
    );

    modport slave (
        input  i_SelA, i_SelB, i_WrAcc, i_Op, i_OutData, i_ExtensionData,
        output o_ACC, o_SelB, o_ALU, o_Zero, o_Carry, o_Ovf
    );
endinterface

// File: rtl/acc_mux_datapath.sv
// Accumulator slice of the BIP CPU: operand muxes, ACC register and an
// adder/subtractor ALU with zero, carry/borrow and signed-overflow flags.
module acc_mux_datapath #(
    parameter int NBITS_D = 16
) (
    input logic               i_clk,
    input logic               i_reset,
    acc_mux_datapath_if.slave bus
);
    localparam int MSB = NBITS_D - 1;

    logic [NBITS_D-1:0] acc;
    logic [NBITS_D-1:0] acc_next;
    logic [NBITS_D-1:0] operand_b;
    logic [NBITS_D-1:0] b_eff;
    logic [NBITS_D-1:0] alu_result;
    logic               carry_out;
    logic               op_sub;
    logic               acc_load;

    assign op_sub    = bus.i_Op;
    assign operand_b = bus.i_SelB ? bus.i_ExtensionData : bus.i_OutData;

    // Subtract reuses the adder as ACC + ~B + 1; the raw carry then means "no borrow".
    assign b_eff = op_sub ? ~operand_b : operand_b;
    assign {carry_out, alu_result} = {1'b0, acc} + {1'b0, b_eff}
                                   + {{NBITS_D{1'b0}}, op_sub};

    always_comb begin
        acc_next = acc;
        acc_load = 1'b0;
        case (bus.i_SelA)
            2'b00: begin
                acc_next = bus.i_OutData;
                acc_load = bus.i_WrAcc;
            end
            2'b01: begin
                acc_next = bus.i_ExtensionData;
                acc_load = bus.i_WrAcc;
            end
            2'b10: begin
                acc_next = alu_result;
                acc_load = bus.i_WrAcc;
            end
            default: begin
                acc_next = acc;
                acc_load = 1'b0;
            end
        endcase
    end

    // The ALU only feeds the register D input, so accumulate uses the pre-edge ACC.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc <= '0;
        end else if (acc_load) begin
            acc <= acc_next;
        end
    end

    assign bus.o_ACC   = acc;
    assign bus.o_SelB  = operand_b;
    assign bus.o_ALU   = alu_result;
    assign bus.o_Zero  = (alu_result == '0);
    assign bus.o_Carry = op_sub ? ~carry_out : carry_out;
    assign bus.o_Ovf   = (acc[MSB] == b_eff[MSB]) && (alu_result[MSB] != acc[MSB]);
endmodule

// File: tb/tb_acc_mux_datapath.sv
// Self-checking bench for acc_mux_datapath: directed scenarios plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_acc_mux_datapath;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic cmp_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] m_acc = '0;

    acc_mux_datapath_if #(.NBITS_D(W)) bus ();

    acc_mux_datapath #(.NBITS_D(W)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU from plain integer arithmetic on unsigned and signed views.
    function automatic void model_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic op, output logic [W-1:0] r,
                                      output logic z, output logic c, output logic v);
        int ua, ub, us, sa, sb, ss;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op) begin
            us = ua - ub;
            ss = sa - sb;
            c  = (ua < ub);
        end else begin
            us = ua + ub;
            ss = sa + sb;
            c  = (us > 65535);
        end
        r = us[W-1:0];
        z = (r == '0);
        v = (ss > 32767) || (ss < -32768);
    endfunction

    function automatic logic [W-1:0] model_b();
        return bus.i_SelB ? bus.i_ExtensionData : bus.i_OutData;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [W-1:0] r;
        logic z, c, v;
        if (reset) begin
            m_acc <= '0;
        end else if (bus.i_WrAcc) begin
            model_alu(m_acc, model_b(), bus.i_Op, r, z, c, v);
            case (bus.i_SelA)
                2'b00:   m_acc <= bus.i_OutData;
                2'b01:   m_acc <= bus.i_ExtensionData;
                2'b10:   m_acc <= r;
                default: m_acc <= m_acc;
            endcase
        end
    end

    task automatic check(input string name, input logic [W-1:0] actual,
                         input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] r;
        logic z, c, v;
        if (cmp_en) begin
            model_alu(m_acc, model_b(), bus.i_Op, r, z, c, v);
            check("cmp_acc",   bus.o_ACC,   m_acc);
            check("cmp_selb",  bus.o_SelB,  model_b());
            check("cmp_alu",   bus.o_ALU,   r);
            check("cmp_zero",  {15'd0, bus.o_Zero},  {15'd0, z});
            check("cmp_carry", {15'd0, bus.o_Carry}, {15'd0, c});
            check("cmp_ovf",   {15'd0, bus.o_Ovf},   {15'd0, v});
        end
    end

    task automatic applyStimulus(input logic [1:0] sel_a, input logic sel_b, input logic wr,
                                 input logic op, input logic [W-1:0] out_data,
                                 input logic [W-1:0] ext_data);
        bus.i_SelA            = sel_a;
        bus.i_SelB            = sel_b;
        bus.i_WrAcc           = wr;
        bus.i_Op              = op;
        bus.i_OutData         = out_data;
        bus.i_ExtensionData   = ext_data;
    endtask

    // Lands 1 time unit after a falling edge, clear of both compare and update.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] acc_exp);
        tick();
        check(name, bus.o_ACC, acc_exp);
    endtask

    task automatic checkFlags(input string name, input logic [W-1:0] alu_exp,
                              input logic z, input logic c, input logic v);
        #1;
        check({name, "_alu"},   bus.o_ALU, alu_exp);
        check({name, "_zero"},  {15'd0, bus.o_Zero},  {15'd0, z});
        check({name, "_carry"}, {15'd0, bus.o_Carry}, {15'd0, c});
        check({name, "_ovf"},   {15'd0, bus.o_Ovf},   {15'd0, v});
    endtask

    function automatic logic [W-1:0] pick_value();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        applyStimulus(2'b10, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h000F);
        #1;
        reset = 1'b1;
        cmp_en = 1'b1;

        // Scenario 1: reset values, then accumulate 0x0F0F three times.
        tick();
        check("rst_acc", bus.o_ACC, 16'h0000);
        checkFlags("rst", 16'h0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'h000F);
        reset = 1'b0;
        checkOutput("acc_edge1", 16'h0F0F);
        check("selb_hold", bus.o_SelB, 16'h0F0F);
        checkOutput("acc_edge2", 16'h1E1E);
        checkOutput("acc_edge3", 16'h2D2D);
        check("selb_hold3", bus.o_SelB, 16'h0F0F);

        // Scenario 2: load, then subtract the immediate.
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'h000F);
        checkOutput("load_0f0f", 16'h0F0F);
        applyStimulus(2'b10, 1'b1, 1'b1, 1'b1, 16'h0F0F, 16'h000F);
        checkFlags("sub_pre", 16'h0F00, 1'b0, 1'b0, 1'b0);
        checkOutput("sub_post", 16'h0F00);

        // Scenario 3: wrap, overflow and borrow with ACC held via SelA=11.
        applyStimulus(2'b01, 1'b0, 1'b1, 1'b0, 16'h0001, 16'hFFFF);
        checkOutput("load_ffff", 16'hFFFF);
        applyStimulus(2'b11, 1'b0, 1'b1, 1'b0, 16'h0001, 16'hFFFF);
        checkFlags("wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'b01, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h7FFF);
        checkOutput("load_7fff", 16'h7FFF);
        applyStimulus(2'b11, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h7FFF);
        checkFlags("ovf", 16'h8000, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b01, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        checkOutput("load_0000", 16'h0000);
        applyStimulus(2'b11, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000);
        checkFlags("borrow", 16'hFFFF, 1'b0, 1'b1, 1'b0);

        // Scenario 4: hold conditions.
        applyStimulus(2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234);
        checkOutput("load_1234", 16'h1234);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00AB);
        checkOutput("hold_wr0", 16'h1234);
        applyStimulus(2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00AB);
        checkOutput("hold_sel11", 16'h1234);
        applyStimulus(2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00AB);
        checkOutput("load_00ab", 16'h00AB);

        // Scenario 5: asynchronous reset pulse between edges mid-accumulate.
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h000F);
        checkOutput("clear", 16'h0000);
        applyStimulus(2'b10, 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'h000F);
        checkOutput("acc5_edge1", 16'h0F0F);
        checkOutput("acc5_edge2", 16'h1E1E);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst", bus.o_ACC, 16'h0000);
        #1;
        reset = 1'b0;
        checkOutput("acc5_restart", 16'h0F0F);

        // Randomized traffic with boundary-biased operands and rare reset pulses.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom), pick_value(), pick_value());
            if ($urandom_range(0, 39) == 0) begin
                #1;
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
